// File: rtl/risc_pkg.sv
// Shared definitions for the EX->MEM pipeline register: control-bit layout,
// default widths and the skid-buffer state encoding.
package risc_pkg;
  localparam int CTRL_W     = 4;
  localparam int CTRL_MREG  = 3;
  localparam int CTRL_ENRW  = 2;
  localparam int CTRL_MW    = 1;
  localparam int CTRL_MR    = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_WN_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;
endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus a packed payload register.
// Load wins over clear; clear drops the valid bit but keeps the payload.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic         o_valid,
  output logic [W-1:0] o_q
);
  logic         r_valid;
  logic [W-1:0] r_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_valid <= 1'b0;
      r_q     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_q     <= i_d;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_q     = r_q;
endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready handshake, flush, and an optional
// 2-entry skid buffer that makes in_ready depend on registered state only.
module ex_mem_pipe_reg
  import risc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WN_W   = DEF_WN_W,
  parameter int SKID   = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_MReg,
  input  logic              in_EnRW,
  input  logic              in_MW,
  input  logic              in_MR,
  input  logic [WN_W-1:0]   in_WN,
  input  logic [DATA_W-1:0] in_ALUResult,
  input  logic [DATA_W-1:0] in_PC,
  input  logic [DATA_W-1:0] in_RD2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_MReg,
  output logic              out_EnRW,
  output logic              out_MW,
  output logic              out_MR,
  output logic [WN_W-1:0]   out_WN,
  output logic [DATA_W-1:0] out_ALUResult,
  output logic [DATA_W-1:0] out_PC,
  output logic [DATA_W-1:0] out_RD2
);
  localparam int PW = CTRL_W + WN_W + 3*DATA_W;

  logic [PW-1:0]     w_in_d;
  logic [PW-1:0]     w_m_q;
  logic              w_m_valid;
  logic              w_accept;
  logic              w_consume;
  logic [CTRL_W-1:0] w_ctrl;

  assign w_in_d    = {in_MReg, in_EnRW, in_MW, in_MR, in_WN, in_ALUResult, in_PC, in_RD2};
  // A flush-cycle accept is dropped, so it never counts as a transfer.
  assign w_accept  = in_valid & in_ready & ~Flush;
  assign w_consume = w_m_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      state_t        r_state, w_nstate;
      logic          w_m_ld, w_m_clr, w_s_ld, w_s_clr;
      logic          w_s_valid;
      logic [PW-1:0] w_s_q;

      always_ff @(posedge Clk) begin
        if (Rst) r_state <= EMPTY;
        else     r_state <= w_nstate;
      end

      always_comb begin
        w_nstate = r_state;
        w_m_ld   = 1'b0;
        w_m_clr  = 1'b0;
        w_s_ld   = 1'b0;
        w_s_clr  = 1'b0;
        if (Flush) begin
          w_nstate = EMPTY;
          w_m_clr  = 1'b1;
          w_s_clr  = 1'b1;
        end else begin
          case (r_state)
            EMPTY: if (w_accept) begin
              w_m_ld   = 1'b1;
              w_nstate = BUSY;
            end
            BUSY: begin
              if (w_accept && w_consume) w_m_ld = 1'b1;
              else if (w_accept) begin
                w_s_ld   = 1'b1;
                w_nstate = FULL;
              end else if (w_consume) begin
                w_m_clr  = 1'b1;
                w_nstate = EMPTY;
              end
            end
            FULL: if (w_consume) begin
              w_m_ld   = 1'b1;
              w_s_clr  = 1'b1;
              w_nstate = BUSY;
            end
            default: w_nstate = EMPTY;
          endcase
        end
      end

      pipe_slot #(.W(PW)) u_main (
        .Clk(Clk), .Rst(Rst), .i_load(w_m_ld), .i_clear(w_m_clr),
        // S is only valid in FULL, where M can only refill from S.
        .i_d(w_s_valid ? w_s_q : w_in_d), .o_valid(w_m_valid), .o_q(w_m_q)
      );

      pipe_slot #(.W(PW)) u_skid (
        .Clk(Clk), .Rst(Rst), .i_load(w_s_ld), .i_clear(w_s_clr),
        .i_d(w_in_d), .o_valid(w_s_valid), .o_q(w_s_q)
      );

      assign in_ready = ~Rst & (r_state != FULL);
    end else begin : g_single
      pipe_slot #(.W(PW)) u_main (
        .Clk(Clk), .Rst(Rst), .i_load(w_accept),
        .i_clear(Flush | (w_consume & ~w_accept)),
        .i_d(w_in_d), .o_valid(w_m_valid), .o_q(w_m_q)
      );

      assign in_ready = ~Rst & (~w_m_valid | out_ready);
    end
  endgenerate

  assign w_ctrl        = w_m_q[PW-1 -: CTRL_W];
  assign out_valid     = w_m_valid;
  assign out_MReg      = w_m_valid & w_ctrl[CTRL_MREG];
  assign out_EnRW      = w_m_valid & w_ctrl[CTRL_ENRW];
  assign out_MW        = w_m_valid & w_ctrl[CTRL_MW];
  assign out_MR        = w_m_valid & w_ctrl[CTRL_MR];
  assign out_WN        = w_m_q[3*DATA_W +: WN_W];
  assign out_ALUResult = w_m_q[2*DATA_W +: DATA_W];
  assign out_PC        = w_m_q[DATA_W +: DATA_W];
  assign out_RD2       = w_m_q[0 +: DATA_W];
endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: one SKID=1 and one SKID=0 instance on shared inputs,
// each checked in turn against a FIFO-queue reference model.
module tb_ex_mem_pipe_reg;
  typedef struct packed {
    logic [3:0]  ctrl;   // {MReg, EnRW, MW, MR}
    logic [3:0]  wn;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rd2;
  } ent_t;

  typedef struct packed {
    logic v;
    logic r;
    ent_t e;
  } obs_t;

  logic Clk = 1'b0;
  logic Rst, Flush, in_valid, out_ready;
  ent_t in_e;
  always #5 Clk = ~Clk;

  logic        v1, r1, mreg1, enrw1, mw1, mr1, v0, r0, mreg0, enrw0, mw0, mr0;
  logic [3:0]  wn1, wn0;
  logic [31:0] alu1, pc1, rd21, alu0, pc0, rd20;

  ex_mem_pipe_reg #(.DATA_W(32), .WN_W(4), .SKID(1)) dut1 (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .in_valid(in_valid), .in_ready(r1),
    .in_MReg(in_e.ctrl[3]), .in_EnRW(in_e.ctrl[2]), .in_MW(in_e.ctrl[1]), .in_MR(in_e.ctrl[0]),
    .in_WN(in_e.wn), .in_ALUResult(in_e.alu), .in_PC(in_e.pc), .in_RD2(in_e.rd2),
    .out_valid(v1), .out_ready(out_ready), .out_MReg(mreg1), .out_EnRW(enrw1),
    .out_MW(mw1), .out_MR(mr1), .out_WN(wn1), .out_ALUResult(alu1), .out_PC(pc1), .out_RD2(rd21));

  ex_mem_pipe_reg #(.DATA_W(32), .WN_W(4), .SKID(0)) dut0 (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .in_valid(in_valid), .in_ready(r0),
    .in_MReg(in_e.ctrl[3]), .in_EnRW(in_e.ctrl[2]), .in_MW(in_e.ctrl[1]), .in_MR(in_e.ctrl[0]),
    .in_WN(in_e.wn), .in_ALUResult(in_e.alu), .in_PC(in_e.pc), .in_RD2(in_e.rd2),
    .out_valid(v0), .out_ready(out_ready), .out_MReg(mreg0), .out_EnRW(enrw0),
    .out_MW(mw0), .out_MR(mr0), .out_WN(wn0), .out_ALUResult(alu0), .out_PC(pc0), .out_RD2(rd20));

  int   n_cmp = 0, n_fail = 0;
  bit   sel;          // 1: check SKID=1 instance, 0: SKID=0 instance
  ent_t q[$];         // entries held by the stage, front = presented to MEM
  ent_t last;         // payload the outputs show while invalid

  function automatic ent_t rnd(input logic [31:0] alu);
    ent_t e;
    e.ctrl = 4'($urandom); e.wn = 4'($urandom);
    e.alu = alu; e.pc = $urandom; e.rd2 = $urandom;
    return e;
  endfunction

  function automatic bit m_ready();
    if (Rst) return 1'b0;
    if (sel) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic obs_t exp_obs();
    obs_t o;
    o.v = q.size() > 0;
    o.r = m_ready();
    o.e = o.v ? q[0] : last;
    if (!o.v) o.e.ctrl = 4'b0;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    if (sel) begin
      o.v = v1; o.r = r1; o.e = '{{mreg1, enrw1, mw1, mr1}, wn1, alu1, pc1, rd21};
    end else begin
      o.v = v0; o.r = r0; o.e = '{{mreg0, enrw0, mw0, mr0}, wn0, alu0, pc0, rd20};
    end
    return o;
  endfunction

  // Advance the model by one clock edge using the inputs present before the edge.
  function automatic bit model_step();
    bit rdy, acc;
    rdy = m_ready();
    acc = 1'b0;
    if (Rst) begin
      q.delete(); last = '0;
    end else if (Flush) begin
      q.delete();
    end else begin
      acc = in_valid && rdy;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(in_e);
    end
    if (q.size() > 0) last = q[0];
    return acc;
  endfunction

  task automatic cyc(output obs_t o, output obs_t e, output bit acc);
    @(negedge Clk);
    o = dut_obs();
    e = exp_obs();
    @(posedge Clk);
    acc = model_step();
    #1;
  endtask

  task automatic idle();
    in_valid = 0; Flush = 0; Rst = 0; out_ready = 1; in_e = rnd(32'h0);
  endtask

  task automatic test_reset();
    obs_t o, e; bit a;
    idle(); Rst = 1;
    @(posedge Clk); void'(model_step()); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) Rst = 0;
      cyc(o, e, a);
      n_cmp++;
      if (o !== e || (i == 0 && (o.v !== 1'b0 || o.e !== '0))) begin
        n_fail++; $display("FAIL reset[%0d] sel=%0d got=%h want=%h", i, sel, o, e);
      end
    end
  endtask

  task automatic test_stream();
    obs_t o, e; bit a;
    idle();
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 8);
      in_e = rnd(32'h10 + c);
      cyc(o, e, a);
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL stream[%0d] sel=%0d got=%h want=%h", c, sel, o, e);
      end
      n_cmp++;
      if (o.v !== (c >= 1 && c <= 8) || (o.v && o.e.alu !== 32'h10 + c - 1)) begin
        n_fail++; $display("FAIL stream_order[%0d] got v=%b alu=%h", c, o.v, o.e.alu);
      end
    end
  endtask

  task automatic test_skid();
    obs_t o, e; bit a;
    logic [31:0] seen[$];
    int k = 0;
    idle(); out_ready = 0; in_valid = 1; in_e = rnd(32'h20);
    for (int c = 0; c < 8; c++) begin
      if (c == 3) begin out_ready = 1; in_valid = 0; end
      cyc(o, e, a);
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL skid[%0d] got=%h want=%h", c, o, e);
      end
      if (c == 2) begin
        n_cmp++;
        if (o.r !== 1'b0 || o.v !== 1'b1) begin
          n_fail++; $display("FAIL skid_full got ready=%b valid=%b want 0/1", o.r, o.v);
        end
      end
      if (o.v && out_ready) seen.push_back(o.e.alu);
      if (a) begin k++; in_e = rnd(32'h20 + k); end
    end
    n_cmp++;
    if (seen.size() != 2 || seen[0] !== 32'h20 || seen[1] !== 32'h21) begin
      n_fail++; $display("FAIL skid_drain got %0d entries first=%h", seen.size(), seen.size() ? seen[0] : 32'hx);
    end
  endtask

  task automatic test_flush();
    obs_t o, e; bit a;
    int k = 0, leaked = 0;
    idle(); out_ready = 0; in_valid = 1; in_e = rnd(32'h30);
    for (int c = 0; c < 7; c++) begin
      if (c == 3) begin Flush = 1; in_e = rnd(32'h3f); end
      if (c == 4) begin Flush = 0; in_valid = 0; out_ready = 1; end
      cyc(o, e, a);
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL flush[%0d] sel=%0d got=%h want=%h", c, sel, o, e);
      end
      if (c >= 4 && (o.v || o.e.ctrl[2] || o.e.ctrl[1])) leaked++;
      if (a) begin k++; in_e = rnd(32'h30 + k); end
    end
    n_cmp++;
    if (leaked != 0) begin
      n_fail++; $display("FAIL flush_leak got %0d valid cycles want 0", leaked);
    end
  endtask

  task automatic test_bubble();
    obs_t o, e; bit a;
    idle();
    for (int c = 0; c < 4; c++) begin
      in_e = rnd(32'h40 + c); in_e.ctrl = 4'b1111; out_ready = c[0];
      cyc(o, e, a);
      n_cmp++;
      if (o !== e || o.e.ctrl[1] !== 1'b0 || o.e.ctrl[2] !== 1'b0) begin
        n_fail++; $display("FAIL bubble[%0d] sel=%0d got=%h want=%h", c, sel, o, e);
      end
    end
  endtask

  task automatic test_rst_busy();
    obs_t o, e; bit a;
    idle(); out_ready = 0; in_valid = 1; in_e = rnd(32'h50);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin Rst = 1; in_e = rnd(32'h51); end
      if (c == 2) begin Rst = 0; in_valid = 0; end
      cyc(o, e, a);
      n_cmp++;
      if (o !== e || (c == 2 && o.v !== 1'b0)) begin
        n_fail++; $display("FAIL rst_busy[%0d] sel=%0d got=%h want=%h", c, sel, o, e);
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e; bit a;
    int k = 0;
    idle(); in_e = rnd(32'h100);
    for (int c = 0; c < 300; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      Flush     = $urandom_range(0, 40) == 0;
      Rst       = $urandom_range(0, 80) == 0;
      cyc(o, e, a);
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL random[%0d] sel=%0d got=%h want=%h", c, sel, o, e);
      end
      if (a) begin k++; in_e = rnd(32'h100 + k); end
    end
  endtask

  initial begin
    idle();
    sel = 1;
    test_reset(); test_stream(); test_skid(); test_flush();
    test_bubble(); test_rst_busy(); test_random();
    sel = 0;
    test_reset(); test_stream(); test_flush();
    test_bubble(); test_rst_busy(); test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
